// File: rtl/lifo_stack_display.sv
// LIFO stack with full/empty/sticky error flags and a sequential
// double-dabble converter driving active-low 7-segment digits of the top entry.
module lifo_stack_display #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 16,
  parameter int DIGITS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            din,
  input  logic                         err_clr,
  output logic [DATA_W-1:0]            top,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         seg_busy,
  output logic [7*DIGITS-1:0]          seg
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = 4 * DIGITS;
  localparam int SW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WRITE} state_t;

  function automatic logic [BW-1:0] dabble_adj(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     count_n;
  logic [CW-1:0]     idx1;
  logic [AW-1:0]     idx2;
  logic [DATA_W-1:0] top_n;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ovf_set;
  logic              unf_set;
  logic              start;

  assign idx1  = count - CW'(1);
  assign idx2  = AW'(count - CW'(2));
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Push-and-pop on an empty stack falls into the plain push branch.
  always_comb begin
    count_n = count;
    top_n   = top;
    wr_en   = 1'b0;
    wr_addr = idx1[AW-1:0];
    wr_data = din;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (push && (!pop || empty)) begin
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_addr = count[AW-1:0];
        count_n = count + CW'(1);
        top_n   = din;
      end
    end else if (pop && !push) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_data = '0;
        count_n = idx1;
        top_n   = (count >= CW'(2)) ? mem[idx2] : '0;
      end
    end else if (push && pop) begin
      wr_en = 1'b1;
      top_n = din;
    end
  end

  assign start = (top_n != top) || ((count_n == '0) != empty);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      count     <= '0;
      top       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      count     <= count_n;
      top       <= top_n;
      overflow  <= ovf_set | (overflow & ~err_clr);
      underflow <= unf_set | (underflow & ~err_clr);
    end
  end

  state_t            state, state_n;
  logic [DATA_W-1:0] bin_q;
  logic [BW-1:0]     bcd_q;
  logic              blank_q;
  logic [SW-1:0]     shifts_q;
  logic [BW-1:0]     bcd_adj;
  logic [7*DIGITS-1:0] seg_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // A new top value always wins: any state jumps back to LOAD.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = IDLE;
      LOAD:    state_n = SHIFT;
      SHIFT:   if (shifts_q == SW'(DATA_W - 1)) state_n = WRITE;
      WRITE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (start) state_n = LOAD;
  end

  always_comb begin
    bcd_adj = dabble_adj(bcd_q);
    for (int i = 0; i < DIGITS; i++) seg_word[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
  end

  // Carries out of the top nibble are dropped, giving top mod 10^DIGITS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      blank_q  <= 1'b1;
      shifts_q <= '0;
      seg_busy <= 1'b0;
      seg      <= '1;
    end else begin
      case (state)
        LOAD: begin
          bin_q    <= top;
          blank_q  <= empty;
          bcd_q    <= '0;
          shifts_q <= '0;
          seg_busy <= 1'b1;
        end
        SHIFT: begin
          bcd_q    <= {bcd_adj[BW-2:0], bin_q[DATA_W-1]};
          bin_q    <= {bin_q[DATA_W-2:0], 1'b0};
          shifts_q <= shifts_q + SW'(1);
        end
        WRITE: begin
          seg      <= blank_q ? '1 : seg_word;
          seg_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lifo_stack_display.sv
// Randomized and directed bench for lifo_stack_display against a queue-based
// stack model and a latency-based display model.
module tb_lifo_stack_display;

  logic        clk = 1'b0;
  logic        rst;
  logic        push, pop, err_clr;
  logic [5:0]  din;
  logic [5:0]  top;
  logic [4:0]  count;
  logic        empty, full, overflow, underflow, seg_busy;
  logic [13:0] seg;

  always #5 clk = ~clk;

  lifo_stack_display #(.DATA_W(6), .DEPTH(16), .DIGITS(2)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .err_clr(err_clr),
    .top(top), .count(count), .empty(empty), .full(full), .overflow(overflow),
    .underflow(underflow), .seg_busy(seg_busy), .seg(seg)
  );

  int n_cmp = 0;
  int n_err = 0;

  int          stk[$];
  bit          m_ovf, m_unf, m_busy;
  bit          chg[0:8];
  int          cval[0:8];
  logic [13:0] m_seg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [13:0] enc(input int v);
    if (v < 0) return 14'h3FFF;
    return {dig((v / 10) % 10), dig(v % 10)};
  endfunction

  function automatic int m_top();
    return (stk.size() == 0) ? 0 : stk[stk.size()-1];
  endfunction

  task automatic model_reset();
    stk.delete();
    m_ovf = 0; m_unf = 0; m_busy = 0;
    m_seg = 14'h3FFF;
    for (int i = 0; i <= 8; i++) begin chg[i] = 0; cval[i] = -1; end
  endtask

  // One clock edge: stack rules, then display timing (write 8 edges after a
  // change unless another change occurred in between).
  task automatic model_edge(input bit p, input bit q, input int d, input bit c);
    int old_top;
    bit old_e, ev_o, ev_u, any;
    old_top = m_top();
    old_e   = (stk.size() == 0);
    ev_o = 0; ev_u = 0;
    if (p && (!q || stk.size() == 0)) begin
      if (stk.size() == 16) ev_o = 1; else stk.push_back(d);
    end else if (q && !p) begin
      if (stk.size() == 0) ev_u = 1; else void'(stk.pop_back());
    end else if (p && q) begin
      stk[stk.size()-1] = d;
    end
    m_ovf = ev_o | (m_ovf & !c);
    m_unf = ev_u | (m_unf & !c);
    for (int i = 8; i > 0; i--) begin chg[i] = chg[i-1]; cval[i] = cval[i-1]; end
    chg[0]  = (m_top() != old_top) || ((stk.size() == 0) != old_e);
    cval[0] = (stk.size() == 0) ? -1 : m_top();
    any = 0;
    for (int i = 1; i <= 7; i++) any |= chg[i];
    m_busy = any;
    if (chg[8] && !any) m_seg = enc(cval[8]);
  endtask

  task automatic compare_all();
    check("count", count, stk.size());
    check("top", top, m_top());
    check("empty", empty, stk.size() == 0);
    check("full", full, stk.size() == 16);
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_unf);
    check("seg_busy", seg_busy, m_busy);
    check("seg", seg, m_seg);
  endtask

  task automatic step(input bit p, input bit q, input int d, input bit c);
    @(negedge clk);
    push = p; pop = q; din = d[5:0]; err_clr = c;
    @(posedge clk);
    model_edge(p, q, d, c);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; push = 0; pop = 0; err_clr = 0; din = '0;
    model_reset();
    #23;
    @(negedge clk) rst = 1'b1;

    idle(10);
    check("reset_seg", seg, 14'h3FFF);

    step(1, 0, 5, 0); step(1, 0, 42, 0); step(1, 0, 63, 0);
    idle(8);
    step(0, 1, 0, 0);
    idle(8);
    check("show42", seg, 14'b0011001_0100100);
    step(0, 1, 0, 0); step(0, 1, 0, 0);
    idle(9);

    for (int v = 1; v <= 16; v++) step(1, 0, v, 0);
    step(1, 0, 17, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);

    step(1, 0, 7, 0); step(1, 1, 9, 0); step(0, 1, 0, 0);
    step(1, 1, 4, 0); step(0, 1, 0, 0);
    idle(9);

    step(1, 0, 12, 0); idle(2); step(1, 0, 34, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      check("no12", seg == enc(12), 1'b0);
    end
    check("show34", seg, enc(34));

    step(1, 0, 1, 0); step(1, 0, 2, 0); step(1, 0, 3, 0);
    idle(3);
    @(negedge clk);
    push = 0; pop = 0; err_clr = 0;
    @(posedge clk);
    model_edge(0, 0, 0, 0);
    #3 rst = 1'b0;
    #1;
    model_reset();
    check("rst_count", count, 0);
    check("rst_top", top, 0);
    check("rst_empty", empty, 1);
    check("rst_busy", seg_busy, 0);
    check("rst_seg", seg, 14'h3FFF);
    @(negedge clk) rst = 1'b1;
    step(1, 0, 9, 0);
    idle(8);
    check("show09", seg, 14'b1000000_0010000);

    for (int i = 0; i < 400; i++) begin
      int r;
      bit c;
      r = $urandom_range(0, 99);
      c = ($urandom_range(0, 19) == 0);
      if (r < 40)      step(1, 0, $urandom_range(0, 63), c);
      else if (r < 70) step(0, 1, 0, c);
      else if (r < 80) step(1, 1, $urandom_range(0, 63), c);
      else             step(0, 0, 0, c);
      if ($urandom_range(0, 9) == 0) idle(9);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
